// File: rtl/sst_flash_sequencer.sv
// SST39SF0x0 pin owner: arbitrates the cartridge read path against a JEDEC command engine (SST_PROG_VERIFY_EN adds a full-byte program read-back).
// Latency: all outputs registered, one clk after the state decision; read pass adds one cycle of address latency.
// Backpressure: cmd_ready is high only in IDLE/FINISH; cmd_valid without cmd_ready and rd_req while busy are ignored.
module sst_flash_sequencer #(
    parameter int                   WE_PULSE_CYC = 4,
    parameter int                   RD_CYC       = 3,
    parameter int                   TIMEOUT_W    = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC  = 24'd5000000
) (
    input  logic        clk,
    input  logic        cold_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [18:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    input  logic        rd_req,
    input  logic [18:0] rd_addr,
    output logic        rd_grant,
    output logic [18:0] sst_addr,
    output logic [7:0]  sst_dq_out,
    output logic        sst_dq_oe,
    input  logic [7:0]  sst_dq_in,
    output logic        sst_ce,
    output logic        sst_oe,
    output logic        sst_we,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] id_data
);
    typedef enum logic [3:0] {
        IDLE, RD_PASS, WR_SETUP, WR_PULSE, WR_HOLD, POLL_RD, ID_RD, ID_EXIT, FINISH
    } state_t;

    localparam logic [1:0] OP_PROG = 2'b00;
    localparam logic [1:0] OP_SECT = 2'b01;
    localparam logic [1:0] OP_ID   = 2'b11;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(WE_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] RD_GAP     = CNT_W'(RD_CYC);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_CYC - 1'b1;
    localparam logic [TIMEOUT_W-1:0] TMO_MAX  = '1;

    state_t               state_q, state_d;
    logic [2:0]           step_q, step_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [1:0]           op_q, op_d;
    logic [18:0]          addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic                 term_q, term_d;
    logic                 fail_q, fail_d;
    logic [15:0]          id_d;
    logic [2:0]           last_step;
    logic                 poll_exp;
`ifdef SST_PROG_VERIFY_EN
    logic                 ver_q, ver_d;
`endif

    logic        ce_d, oe_d, we_d, dq_oe_d, ready_d, grant_d, busy_d, done_d, err_d;
    logic [18:0] sst_addr_d;
    logic [7:0]  dq_out_d;

    // JEDEC write table; a terminal write is always the reset/exit command 00000/F0.
    function automatic logic [26:0] wr_word(input logic [1:0] op, input logic [2:0] step,
                                            input logic term, input logic [18:0] a,
                                            input logic [7:0] d);
        if (term) return {19'h00000, 8'hF0};
        case (step)
            3'd0:    return {19'h05555, 8'hAA};
            3'd1:    return {19'h02AAA, 8'h55};
            3'd2:    return (op == OP_PROG) ? {19'h05555, 8'hA0} :
                            (op == OP_ID)   ? {19'h05555, 8'h90} : {19'h05555, 8'h80};
            3'd3:    return (op == OP_PROG) ? {a, d} : {19'h05555, 8'hAA};
            3'd4:    return {19'h02AAA, 8'h55};
            default: return (op == OP_SECT) ? {a[18:12], 12'h000, 8'h30} : {19'h05555, 8'h10};
        endcase
    endfunction

    function automatic logic [18:0] poll_addr(input logic [1:0] op, input logic [18:0] a);
        case (op)
            OP_PROG: return a;
            OP_SECT: return {a[18:12], 12'h000};
            default: return 19'h00000;
        endcase
    endfunction

    always_comb begin
        last_step = 3'd5;
        if (op_q == OP_PROG)    last_step = 3'd3;
        else if (op_q == OP_ID) last_step = 3'd2;
        poll_exp = (op_q == OP_PROG) ? data_q[7] : 1'b1;
    end

    // Next-state process
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        term_d  = term_q;
        fail_d  = fail_q;
        id_d    = id_data;
`ifdef SST_PROG_VERIFY_EN
        ver_d   = ver_q;
`endif
        case (state_q)
            // FINISH advertises cmd_ready, so it must honour a handshake like IDLE does.
            IDLE, FINISH: begin
                state_d = IDLE;
                if (rd_req) begin
                    state_d = RD_PASS;
                end else if (cmd_valid && cmd_ready) begin
                    state_d = WR_SETUP;
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    data_d  = cmd_data;
                    step_d  = 3'd0;
                    term_d  = 1'b0;
                    fail_d  = 1'b0;
`ifdef SST_PROG_VERIFY_EN
                    ver_d   = 1'b0;
`endif
                end
            end
            RD_PASS: if (!rd_req) state_d = IDLE;
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = '0;
            end
            WR_PULSE: begin
                if (cnt_q == PULSE_LAST) state_d = WR_HOLD;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            WR_HOLD: begin
                cnt_d = '0;
                if (term_q) begin
                    state_d = FINISH;
                end else if (step_q == last_step) begin
                    step_d = 3'd0;
                    if (op_q == OP_ID) begin
                        state_d = ID_RD;
                    end else begin
                        state_d = POLL_RD;
                        tmo_d   = '0;
                    end
                end else begin
                    step_d  = step_q + 1'b1;
                    state_d = WR_SETUP;
                end
            end
            POLL_RD: begin
                tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
                cnt_d = (cnt_q == RD_GAP) ? '0 : cnt_q + 1'b1;
`ifdef SST_PROG_VERIFY_EN
                if (ver_q) begin
                    if (cnt_q == RD_LAST) begin
                        state_d = FINISH;
                        fail_d  = (sst_dq_in != data_q);
                    end
                end else
`endif
                if (cnt_q == RD_LAST && sst_dq_in[7] == poll_exp) begin
`ifdef SST_PROG_VERIFY_EN
                    if (op_q == OP_PROG) begin
                        ver_d = 1'b1;
                        cnt_d = RD_GAP;
                    end else begin
                        state_d = FINISH;
                    end
`else
                    state_d = FINISH;
`endif
                end else if (tmo_q == TMO_LAST) begin
                    state_d = WR_SETUP;
                    term_d  = 1'b1;
                    fail_d  = 1'b1;
                end
            end
            ID_RD: begin
                cnt_d = (cnt_q == RD_GAP) ? '0 : cnt_q + 1'b1;
                if (cnt_q == RD_LAST) begin
                    if (!step_q[0]) begin
                        id_d[15:8] = sst_dq_in;
                        step_d     = 3'd1;
                    end else begin
                        id_d[7:0] = sst_dq_in;
                        step_d    = 3'd0;
                        state_d   = ID_EXIT;
                    end
                end
            end
            ID_EXIT: begin
                state_d = WR_SETUP;
                term_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so every pin is a plain register.
    always_comb begin
        ce_d       = 1'b1;
        oe_d       = 1'b1;
        we_d       = 1'b1;
        dq_oe_d    = 1'b0;
        sst_addr_d = sst_addr;
        dq_out_d   = sst_dq_out;
        ready_d    = 1'b0;
        grant_d    = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_d)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            FINISH: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = !fail_d;
                err_d   = fail_d;
            end
            RD_PASS: begin
                grant_d    = 1'b1;
                busy_d     = 1'b0;
                ce_d       = 1'b0;
                oe_d       = 1'b0;
                sst_addr_d = rd_addr;
            end
            WR_SETUP, WR_PULSE, WR_HOLD: begin
                ce_d    = 1'b0;
                dq_oe_d = 1'b1;
                we_d    = (state_d != WR_PULSE);
                {sst_addr_d, dq_out_d} = wr_word(op_d, step_d, term_d, addr_d, data_d);
            end
            POLL_RD: begin
                ce_d       = !(cnt_d < RD_GAP);
                oe_d       = !(cnt_d < RD_GAP);
                sst_addr_d = poll_addr(op_d, addr_d);
            end
            ID_RD: begin
                ce_d       = !(cnt_d < RD_GAP);
                oe_d       = !(cnt_d < RD_GAP);
                sst_addr_d = {18'h00000, step_d[0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge cold_reset) begin
        if (!cold_reset) begin
            state_q    <= IDLE;
            step_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            term_q     <= 1'b0;
            fail_q     <= 1'b0;
            sst_ce     <= 1'b1;
            sst_oe     <= 1'b1;
            sst_we     <= 1'b1;
            sst_dq_oe  <= 1'b0;
            sst_addr   <= '0;
            sst_dq_out <= '0;
            cmd_ready  <= 1'b0;
            rd_grant   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            id_data    <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            term_q     <= term_d;
            fail_q     <= fail_d;
            sst_ce     <= ce_d;
            sst_oe     <= oe_d;
            sst_we     <= we_d;
            sst_dq_oe  <= dq_oe_d;
            sst_addr   <= sst_addr_d;
            sst_dq_out <= dq_out_d;
            cmd_ready  <= ready_d;
            rd_grant   <= grant_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= err_d;
            id_data    <= id_d;
        end
    end

`ifdef SST_PROG_VERIFY_EN
    always_ff @(posedge clk or negedge cold_reset) begin
        if (!cold_reset) ver_q <= 1'b0;
        else             ver_q <= ver_d;
    end
`endif
endmodule

// File: tb/tb_sst_flash_sequencer.sv
// Bench for sst_flash_sequencer: behavioural flash model plus expected JEDEC write lists, directed and random commands.
module tb_sst_flash_sequencer;
    localparam int WE_CYC  = 4;
    localparam int RD_CYC  = 3;
    localparam int TMO_CYC = 100;

    logic        clk = 1'b0;
    logic        cold_reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [18:0] cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic        rd_req = 1'b0, rd_grant;
    logic [18:0] rd_addr = '0;
    logic [18:0] sst_addr;
    logic [7:0]  sst_dq_out, sst_dq_in = '0;
    logic        sst_dq_oe, sst_ce, sst_oe, sst_we, busy, done, error;
    logic [15:0] id_data;

    sst_flash_sequencer #(.WE_PULSE_CYC(WE_CYC), .RD_CYC(RD_CYC), .TIMEOUT_W(24),
                          .TIMEOUT_CYC(24'(TMO_CYC))) dut (
        .clk(clk), .cold_reset(cold_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_grant(rd_grant), .sst_addr(sst_addr), .sst_dq_out(sst_dq_out),
        .sst_dq_oe(sst_dq_oe), .sst_dq_in(sst_dq_in), .sst_ce(sst_ce), .sst_oe(sst_oe),
        .sst_we(sst_we), .busy(busy), .done(done), .error(error), .id_data(id_data));

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;

    // Flash model state and bus observations
    int          busy_left = 0;
    logic [7:0]  fin_val = '0, id_man = '0, id_dev = '0;
    bit          id_mode = 0;
    int          cyc = 0, n_reads = 0, done_cnt = 0, err_cnt = 0;
    int          both_cnt = 0, fin_bad = 0, proto_bad = 0, we_run = 0;
    logic        we_prev = 1'b1, oe_prev = 1'b1;
    logic [18:0] cur_a = '0;
    logic [7:0]  cur_d = '0;
    logic [18:0] wa_q[$], ea_q[$];
    logic [7:0]  wd_q[$], ed_q[$];
    int          wl_q[$], first_q[$], last_q[$];
    logic [15:0] exp_id = '0;

    always @(negedge clk) begin
        if (!cold_reset) begin
            we_prev = 1'b1;
            oe_prev = 1'b1;
            we_run  = 0;
        end else begin
            cyc++;
            if (done && error) both_cnt++;
            if (done) begin done_cnt++; if (!cmd_ready || busy) fin_bad++; end
            if (error) begin err_cnt++; if (!cmd_ready || busy) fin_bad++; end
            if (!sst_we) begin
                if (we_prev) first_q.push_back(cyc);
                we_run++;
                cur_a = sst_addr;
                cur_d = sst_dq_out;
                if (sst_ce || !sst_oe || !sst_dq_oe) proto_bad++;
            end else if (!we_prev) begin
                wa_q.push_back(cur_a);
                wd_q.push_back(cur_d);
                wl_q.push_back(we_run);
                last_q.push_back(cyc - 1);
                we_run = 0;
            end
            if (!sst_oe && sst_dq_oe) proto_bad++;
            if (!sst_oe && oe_prev && !rd_grant) begin
                n_reads++;
                if (id_mode)            sst_dq_in = sst_addr[0] ? id_dev : id_man;
                else if (busy_left > 0) begin
                    sst_dq_in = {~fin_val[7], fin_val[6:0] ^ 7'h55};
                    busy_left--;
                end else                sst_dq_in = fin_val;
            end
            we_prev = sst_we;
            oe_prev = sst_oe;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_w(input logic [18:0] a, input logic [7:0] d);
        ea_q.push_back(a);
        ed_q.push_back(d);
    endtask

    // Reference: JEDEC software sequences written out as plain write lists.
    task automatic model(input logic [1:0] op, input logic [18:0] a, input logic [7:0] d, input bit tmo);
        ea_q.delete();
        ed_q.delete();
        push_w(19'h05555, 8'hAA);
        push_w(19'h02AAA, 8'h55);
        if (op == 2'b00) begin
            push_w(19'h05555, 8'hA0);
            push_w(a, d);
        end else if (op == 2'b11) begin
            push_w(19'h05555, 8'h90);
            push_w(19'h00000, 8'hF0);
        end else begin
            push_w(19'h05555, 8'h80);
            push_w(19'h05555, 8'hAA);
            push_w(19'h02AAA, 8'h55);
            if (op == 2'b01) push_w({a[18:12], 12'h000}, 8'h30);
            else             push_w(19'h05555, 8'h10);
        end
        if (tmo) push_w(19'h00000, 8'hF0);
    endtask

    task automatic setup_model(input logic [1:0] op, input logic [7:0] d, input int nb,
                               input logic [7:0] man, input logic [7:0] dev);
        busy_left = nb;
        fin_val   = (op == 2'b00) ? d : 8'hFF;
        id_mode   = (op == 2'b11);
        id_man    = man;
        id_dev    = dev;
        if (op == 2'b11) exp_id = {man, dev};
        wa_q.delete(); wd_q.delete(); wl_q.delete(); first_q.delete(); last_q.delete();
        n_reads = 0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [18:0] a, input logic [7:0] d);
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (cmd_ready) ok = 1;
            else tick();
        end
        check("ready_before_cmd", ok, 1);
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("accept_busy_ready", {busy, cmd_ready}, 2'b10);
    endtask

    task automatic finish_cmd(input logic [1:0] op, input logic [18:0] a, input logic [7:0] d,
                              input int nb, input bit tmo, input int d0, input int e0);
        bit got = 0;
        int nw, exp_rd;
        for (int i = 0; i < 4000 && !got; i++) begin
            tick();
            if (done_cnt != d0 || err_cnt != e0) got = 1;
        end
        check("cmd_complete", got, 1);
        tick();
        model(op, a, d, tmo);
        check("wr_count", wa_q.size(), ea_q.size());
        nw = (wa_q.size() < ea_q.size()) ? wa_q.size() : ea_q.size();
        for (int i = 0; i < nw; i++) begin
            check($sformatf("wr_addr[%0d]", i), wa_q[i], ea_q[i]);
            check($sformatf("wr_data[%0d]", i), wd_q[i], ed_q[i]);
            check($sformatf("we_len[%0d]", i), wl_q[i], WE_CYC);
        end
        check("done_pulses", done_cnt - d0, tmo ? 0 : 1);
        check("error_pulses", err_cnt - e0, tmo ? 1 : 0);
        if (tmo)             exp_rd = (TMO_CYC + RD_CYC) / (RD_CYC + 1);
        else if (op == 2'b11) exp_rd = 2;
        else                 exp_rd = nb + 1;
`ifdef SST_PROG_VERIFY_EN
        if (!tmo && op == 2'b00) exp_rd = exp_rd + 1;
`endif
        check("read_count", n_reads, exp_rd);
        check("idle_after", {cmd_ready, busy, sst_ce, sst_oe, sst_we, sst_dq_oe}, 6'b101110);
        check("id_data", id_data, exp_id);
        check("end_pulse_ready", fin_bad, 0);
        if (tmo && first_q.size() == 7 && last_q.size() >= 6)
            check("timeout_span", first_q[6] - last_q[5], 1 + TMO_CYC + 1 + 1);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [18:0] a, input logic [7:0] d,
                           input int nb, input bit tmo, input logic [7:0] man, input logic [7:0] dev);
        int d0, e0;
        setup_model(op, d, nb, man, dev);
        d0 = done_cnt;
        e0 = err_cnt;
        issue(op, a, d);
        finish_cmd(op, a, d, nb, tmo, d0, e0);
    endtask

    initial begin
        int d0, e0;
        bit hit;
        logic [18:0] ra;
        #2 cold_reset = 1'b0;
        #1 check("in_reset_pins", {sst_ce, sst_oe, sst_we, sst_dq_oe, cmd_ready, busy}, 6'b111000);
        tick(); tick();
        cold_reset = 1'b1;
        check("ready_at_release", cmd_ready, 0);
        tick();
        check("reset_ready", cmd_ready, 1);
        check("reset_strobes", {sst_ce, sst_oe, sst_we, sst_dq_oe}, 4'b1110);
        check("reset_flags", {rd_grant, busy, done, error}, 4'b0000);
        check("reset_id", id_data, 16'h0000);
        check("reset_addr", {sst_addr, sst_dq_out}, 27'h0);

        run_cmd(2'b00, 19'h01234, 8'h5A, 10, 0, 8'h00, 8'h00);
        run_cmd(2'b11, 19'h00000, 8'h00, 0, 0, 8'hBF, 8'hB7);
        check("id_bfb7", id_data, 16'hBFB7);

        // Read path wins a simultaneous request; the command waits for rd_req to fall.
        setup_model(2'b10, 8'h00, 3, 8'h00, 8'h00);
        d0 = done_cnt; e0 = err_cnt;
        ra = 19'($urandom);
        rd_addr = ra; rd_req = 1'b1;
        cmd_op = 2'b10; cmd_addr = 19'h0; cmd_data = 8'h0; cmd_valid = 1'b1;
        tick();
        check("rd_grant_on", {rd_grant, cmd_ready, busy, sst_ce, sst_oe, sst_dq_oe}, 6'b100000);
        check("rd_addr_first", sst_addr, ra);
        for (int i = 0; i < 3; i++) begin
            ra = 19'($urandom);
            rd_addr = ra;
            tick();
            check("rd_addr_follow", sst_addr, ra);
        end
        check("no_write_in_rd", wa_q.size(), 0);
        rd_req = 1'b0;
        tick();
        check("rd_release", {rd_grant, sst_ce, sst_oe, busy, cmd_ready}, 5'b01101);
        tick();
        check("cmd_after_rd", busy, 1);
        cmd_valid = 1'b0;
        finish_cmd(2'b10, 19'h0, 8'h0, 3, 0, d0, e0);

        run_cmd(2'b01, 19'h3FFFF, 8'h00, 1000000, 1, 8'h00, 8'h00);

        // Asynchronous reset during the second write's WE pulse.
        setup_model(2'b00, 8'hC3, 2, 8'h00, 8'h00);
        issue(2'b00, 19'h00777, 8'hC3);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            if (wa_q.size() == 1 && !sst_we) hit = 1;
        end
        check("reached_pulse2", hit, 1);
        #1 cold_reset = 1'b0;
        #1 check("async_reset_pins", {sst_we, sst_dq_oe, sst_ce, busy, cmd_ready}, 5'b10100);
        tick(); tick();
        cold_reset = 1'b1;
        check("ready_at_release2", cmd_ready, 0);
        tick();
        check("idle_after_reset", {cmd_ready, busy, sst_ce, sst_oe, sst_we, sst_dq_oe, id_data == 16'h0},
              7'b1011101);
        exp_id = 16'h0000;
        run_cmd(2'b10, 19'h0, 8'h0, 4, 0, 8'h00, 8'h00);

        for (int k = 0; k < 8; k++) begin
            run_cmd(2'($urandom_range(0, 3)), 19'($urandom), 8'($urandom),
                    int'($urandom_range(0, 12)), 0, 8'($urandom), 8'($urandom));
        end

        check("done_error_overlap", both_cnt, 0);
        check("bus_protocol", proto_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
